lr35902_dbg_watch: RTL and testbench
====================================

# lr35902_dbg_watch

Memory watchpoint unit for the LR35902 debug path. It snoops CPU bus accesses and compares them against NUM_WP programmable address watchpoints, each with a pass count. On a trigger it captures the access and raises a sticky halt request. The debug controller directly downstream ORs that request into the CPU halt and reads the captured record back bytewise through its probe mux.

## Interface
- NUM_WP, default 2: number of watchpoints, 1..4.
- cpu_clk  in  1  CPU clock; all state changes on its rising edge.
- reset  in  1  reset, synchronous, active-high; clock cpu_clk.
- adr  in  16  CPU bus address.
- dbus  in  8  data on the bus: write data on writes, returned data on reads.
- rd  in  1  bus read strobe; one cycle per access.
- wr  in  1  bus write strobe; one cycle per access; never high together with rd.
- cfg_we  in  1  configuration write strobe.
- cfg_wp  in  2  watchpoint index for cfg_we; indices ≥ NUM_WP are ignored.
- cfg_field  in  2  0 = address nibble shift, 1 = mode, 2 = pass count, 3 = reserved (ignored).
- cfg_nib  in  4  configuration nibble.
- clr  in  1  acknowledge trigger; clears halt_req.
- cap_sel  in  2  selects the capture byte presented on cap_byte.
- halt_req  out  1  sticky trigger flag; reset 0.
- cap_byte  out  8  capture readout, combinational from cap_sel; reset value is that of cap_sel=0 (0x00).

## Operation
- Per-watchpoint registers:
  - addr[15:0]: reset 0xFFFF. Field-0 write does addr = {cfg_nib, addr[15:4]}; four writes load a full address, least significant nibble first.
  - mode[1:0]: reset 00. Encodings 00 off, 01 read, 10 write, 11 read or write. Field-1 write takes cfg_nib[1:0].
  - cnt[3:0]: reset 0. Field-2 write sets cnt = cfg_nib and rem = cfg_nib.
  - rem[3:0]: remaining passes; reset 0.
- Match (watchpoint i): mode≠00, adr==addr, and (rd & mode[0] | wr & mode[1]).
- Hit handling, evaluated only while halt_req=0:
  - Every matching watchpoint with rem≠0 does rem−1.
  - A matching watchpoint with rem==0 triggers and reloads rem=cnt.
  - A cnt of N therefore triggers on hit N+1.
- Trigger:
  - halt_req←1.
  - The capture record is loaded from the lowest-index triggering watchpoint: cap_adr←adr, cap_data←dbus, cap_wr←wr, cap_idx←index.
  - Other watchpoints triggering in the same cycle still reload rem; their triggers are not recorded.
- While halt_req=1: matches are ignored. There is no rem change and no capture overwrite.
- clr: halt_req←0 next edge; capture registers are kept. clr together with a match: clr wins and the match is discarded entirely (no rem change).
- Configuration:
  - cfg_we in the same cycle as a match on the same watchpoint: the configuration write wins; the match is ignored for that watchpoint.
  - Writes are accepted regardless of halt_req.
- cap_sel: 0 = cap_adr[7:0], 1 = cap_adr[15:8], 2 = cap_data, 3 = {cap_wr, 3'b000, 2'b00, cap_idx}.
- Capture registers reset to 0.
- Reset mid-operation clears halt_req, all watchpoints and all capture registers; a pending access in that cycle is dropped.

## Timing
- Bus strobes are sampled at the edge ending their cycle. halt_req is high on the first cycle after the triggering access (latency 1, registered), early enough for the downstream controller to stop the CPU at the next fetch.
- A configuration write is effective for accesses in the following cycle.
- clr deasserts halt_req one cycle later. An access in the cycle after clr is eligible to trigger again.
- cap_byte has no latency relative to cap_sel. Capture data is valid from the cycle halt_req rises.

## Structure
- Shared package lr35902_dbg_pkg:
  - mode constants WP_OFF/WP_RD/WP_WR/WP_RW.
  - cfg_field constants CFG_ADDR/CFG_MODE/CFG_CNT.
  - cap_sel constants CAP_ALO/CAP_AHI/CAP_DATA/CAP_INFO.
- Sub-module lr35902_dbg_wp_unit: one watchpoint. It holds addr/mode/cnt/rem and their configuration decode, and outputs match and trigger.
- The top level instantiates NUM_WP units and contains the lowest-index priority encoder, the halt_req flag, the capture registers and the readout mux.

## Test plan
- Reset, then read cap_sel 0..3 → 0x00 each, halt_req=0. A read at 0xFFFF → no trigger (mode off).
- WP0: nibbles 0,0,1,C → addr 0xC100, mode RW, cnt 0. Write 0x5A to 0xC100 → halt_req=1 next cycle; cap bytes 0x00, 0xC1, 0x5A, 0x80.
- WP1: addr 0xFF40, mode RD, cnt 2. Three reads → trigger only on the third. An interleaved write to 0xFF40 → no effect.
- WP0 and WP1 both at 0x8000 with cnt 0, then an access to 0x8000 → cap_idx=0. After clr the next access triggers again, and both units have reloaded rem.
- With halt_req=1, an access matching WP1 → capture unchanged and rem unchanged. clr plus a matching access in the same cycle → halt_req=0 and rem unchanged.
- Assert reset while halt_req=1 → all outputs return to reset values; a subsequent access to the old address does not trigger.

Source files
------------

// File: rtl/lr35902_dbg_pkg.sv
// lr35902_dbg_pkg: shared constants and capture record type for the LR35902 debug path.
package lr35902_dbg_pkg;
    localparam logic [1:0] WP_OFF = 2'b00;
    localparam logic [1:0] WP_RD  = 2'b01;
    localparam logic [1:0] WP_WR  = 2'b10;
    localparam logic [1:0] WP_RW  = 2'b11;

    localparam logic [1:0] CFG_ADDR = 2'd0;
    localparam logic [1:0] CFG_MODE = 2'd1;
    localparam logic [1:0] CFG_CNT  = 2'd2;

    localparam logic [1:0] CAP_ALO  = 2'd0;
    localparam logic [1:0] CAP_AHI  = 2'd1;
    localparam logic [1:0] CAP_DATA = 2'd2;
    localparam logic [1:0] CAP_INFO = 2'd3;

    typedef struct packed {
        logic        wr;
        logic [1:0]  idx;
        logic [7:0]  data;
        logic [15:0] adr;
    } cap_t;
endpackage

// File: rtl/lr35902_dbg_wp_unit.sv
// lr35902_dbg_wp_unit: one address watchpoint with pass counter.
module lr35902_dbg_wp_unit
    import lr35902_dbg_pkg::*;
(
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic [15:0] adr_i,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic        cfg_we_i,
    input  logic [1:0]  cfg_field_i,
    input  logic [3:0]  cfg_nib_i,
    input  logic        hit_i,
    output logic        match_o,
    output logic        trig_o
);
    logic [15:0] addr_q, addr_d;
    logic [1:0]  mode_q, mode_d;
    logic [3:0]  cnt_q, cnt_d, rem_q, rem_d;

    // A configuration write to this unit shadows any bus match in the same cycle.
    always_comb begin
        match_o = mode_q != WP_OFF && adr_i == addr_q && ((rd_i && mode_q[0]) || (wr_i && mode_q[1])) && !cfg_we_i;
        trig_o  = hit_i && rem_q == 4'd0;
        addr_d  = (cfg_we_i && cfg_field_i == CFG_ADDR) ? {cfg_nib_i, addr_q[15:4]} : addr_q;
        mode_d  = (cfg_we_i && cfg_field_i == CFG_MODE) ? cfg_nib_i[1:0] : mode_q;
        cnt_d   = (cfg_we_i && cfg_field_i == CFG_CNT) ? cfg_nib_i : cnt_q;
        rem_d   = (cfg_we_i && cfg_field_i == CFG_CNT) ? cfg_nib_i :
                  !hit_i ? rem_q : trig_o ? cnt_q : rem_q - 4'd1;
    end

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            addr_q <= 16'hFFFF;
            mode_q <= WP_OFF;
            cnt_q  <= 4'd0;
            rem_q  <= 4'd0;
        end else begin
            addr_q <= addr_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
        end
    end
endmodule

// File: rtl/lr35902_dbg_watch.sv
// lr35902_dbg_watch: bus watchpoints with sticky halt request and bytewise capture readout.
module lr35902_dbg_watch
    import lr35902_dbg_pkg::*;
#(
    parameter int NUM_WP = 2
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic [15:0] adr,
    input  logic [7:0]  dbus,
    input  logic        rd,
    input  logic        wr,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_wp,
    input  logic [1:0]  cfg_field,
    input  logic [3:0]  cfg_nib,
    input  logic        clr,
    input  logic [1:0]  cap_sel,
    output logic        halt_req,
    output logic [7:0]  cap_byte
);
    logic [NUM_WP-1:0] match, trig;
    logic              en, halt_q, halt_d;
    logic [1:0]        idx;
    cap_t              cap_q, cap_d;

    // Matches only count while idle and not being acknowledged.
    assign en = !halt_q && !clr;

    for (genvar g = 0; g < NUM_WP; g++) begin : g_wp
        lr35902_dbg_wp_unit u_wp (
            .cpu_clk     (cpu_clk),
            .reset       (reset),
            .adr_i       (adr),
            .rd_i        (rd),
            .wr_i        (wr),
            .cfg_we_i    (cfg_we && cfg_wp == 2'(g)),
            .cfg_field_i (cfg_field),
            .cfg_nib_i   (cfg_nib),
            .hit_i       (match[g] && en),
            .match_o     (match[g]),
            .trig_o      (trig[g])
        );
    end

    always_comb begin
        idx = 2'd0;
        for (int i = NUM_WP - 1; i >= 0; i--)
            if (trig[i]) idx = 2'(i);
        halt_d   = clr ? 1'b0 : halt_q || |trig;
        cap_d    = |trig ? '{wr: wr, idx: idx, data: dbus, adr: adr} : cap_q;
        halt_req = halt_q;
        cap_byte = cap_sel == CAP_ALO  ? cap_q.adr[7:0] :
                   cap_sel == CAP_AHI  ? cap_q.adr[15:8] :
                   cap_sel == CAP_DATA ? cap_q.data : {cap_q.wr, 5'b00000, cap_q.idx};
    end

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            halt_q <= 1'b0;
            cap_q  <= '0;
        end else begin
            halt_q <= halt_d;
            cap_q  <= cap_d;
        end
    end
endmodule

// File: tb/tb_lr35902_dbg_watch.sv
// tb_lr35902_dbg_watch: directed vector table plus randomized traffic against a reference model.
module tb_lr35902_dbg_watch;
    import lr35902_dbg_pkg::*;
    localparam int N = 2;

    logic        cpu_clk = 1'b0;
    logic        reset = 1'b0, rd = 1'b0, wr = 1'b0, cfg_we = 1'b0, clr = 1'b0;
    logic [15:0] adr = '0;
    logic [7:0]  dbus = '0;
    logic [1:0]  cfg_wp = '0, cfg_field = '0, cap_sel = '0;
    logic [3:0]  cfg_nib = '0;
    logic        halt_req;
    logic [7:0]  cap_byte;

    int checks = 0, errors = 0;

    lr35902_dbg_watch #(.NUM_WP(N)) dut (
        .cpu_clk(cpu_clk), .reset(reset), .adr(adr), .dbus(dbus), .rd(rd), .wr(wr),
        .cfg_we(cfg_we), .cfg_wp(cfg_wp), .cfg_field(cfg_field), .cfg_nib(cfg_nib),
        .clr(clr), .cap_sel(cap_sel), .halt_req(halt_req), .cap_byte(cap_byte)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic        rst, we;
        logic [1:0]  wp, fld;
        logic [3:0]  nib;
        logic        rd, wr;
        logic [15:0] adr;
        logic [7:0]  db;
        logic        clr, eh;
        logic [31:0] ec;
    } vec_t;

    vec_t tbl[$];

    // Reference state: what the spec says each watchpoint and the capture hold.
    logic [15:0] m_addr[N];
    logic [1:0]  m_mode[N];
    logic [3:0]  m_cnt[N], m_rem[N];
    logic        m_halt;
    logic [15:0] m_cadr;
    logic [7:0]  m_cdata;
    logic        m_cwr;
    logic [1:0]  m_cidx;

    function automatic logic [31:0] m_cap();
        return {m_cwr, 5'b00000, m_cidx, m_cdata, m_cadr};
    endfunction

    task automatic model_step();
        int first;
        logic hit;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_addr[i] = 16'hFFFF; m_mode[i] = 2'b00; m_cnt[i] = 4'd0; m_rem[i] = 4'd0;
            end
            m_halt = 1'b0; m_cadr = '0; m_cdata = '0; m_cwr = 1'b0; m_cidx = '0;
            return;
        end
        first = -1;
        for (int i = 0; i < N; i++) begin
            hit = !m_halt && !clr && m_mode[i] != 2'b00 && adr == m_addr[i] &&
                  ((rd && m_mode[i][0]) || (wr && m_mode[i][1])) && !(cfg_we && 32'(cfg_wp) == i);
            if (hit) begin
                if (m_rem[i] == 4'd0) begin
                    m_rem[i] = m_cnt[i];
                    if (first < 0) first = i;
                end else m_rem[i] = m_rem[i] - 4'd1;
            end
            if (cfg_we && 32'(cfg_wp) == i) begin
                case (cfg_field)
                    2'd0: m_addr[i] = {cfg_nib, m_addr[i][15:4]};
                    2'd1: m_mode[i] = cfg_nib[1:0];
                    2'd2: begin m_cnt[i] = cfg_nib; m_rem[i] = cfg_nib; end
                    default: ;
                endcase
            end
        end
        if (clr) m_halt = 1'b0;
        else if (first >= 0) begin
            m_halt = 1'b1; m_cadr = adr; m_cdata = dbus; m_cwr = wr; m_cidx = 2'(first);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; cfg_we = v.we; cfg_wp = v.wp; cfg_field = v.fld; cfg_nib = v.nib;
        rd = v.rd; wr = v.wr; adr = v.adr; dbus = v.db; clr = v.clr;
        model_step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic check(input string nm, input logic eh, input logic [31:0] ec);
        checks++;
        if (halt_req !== eh) begin
            errors++;
            $display("FAIL %s halt_req got %0b want %0b", nm, halt_req, eh);
        end
        for (int s = 0; s < 4; s++) begin
            cap_sel = 2'(s);
            #1;
            checks++;
            if (cap_byte !== ec[8*s +: 8]) begin
                errors++;
                $display("FAIL %s cap_sel=%0d got %02h want %02h", nm, s, cap_byte, ec[8*s +: 8]);
            end
        end
    endtask

    function automatic vec_t R();
        vec_t v = '{default: '0};
        v.rst = 1'b1;
        return v;
    endfunction

    function automatic vec_t C(input logic [1:0] wp, input logic [1:0] fld, input logic [3:0] nib,
                               input logic eh, input logic [31:0] ec);
        vec_t v = '{default: '0};
        v.we = 1'b1; v.wp = wp; v.fld = fld; v.nib = nib; v.eh = eh; v.ec = ec;
        return v;
    endfunction

    function automatic vec_t A(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d,
                               input logic c, input logic eh, input logic [31:0] ec);
        vec_t v = '{default: '0};
        v.rd = r; v.wr = w; v.adr = a; v.db = d; v.clr = c; v.eh = eh; v.ec = ec;
        return v;
    endfunction

    localparam logic [31:0] K1 = 32'h805AC100, K2 = 32'h0133FF40, K3 = 32'h0166FF40;
    localparam logic [31:0] K4 = 32'h00778000, K5 = 32'h00888000, K6 = 32'h01998000;

    logic [15:0] pool[4] = '{16'hC100, 16'hFF40, 16'h8000, 16'h0042};

    initial begin
        vec_t v;
        logic [15:0] p;
        int r;
        tbl.push_back(R());
        tbl.push_back(A(1, 0, 16'hFFFF, 8'h12, 0, 0, 0));
        tbl.push_back(C(0, CFG_ADDR, 4'h0, 0, 0));
        tbl.push_back(C(0, CFG_ADDR, 4'h0, 0, 0));
        tbl.push_back(C(0, CFG_ADDR, 4'h1, 0, 0));
        tbl.push_back(C(0, CFG_ADDR, 4'hC, 0, 0));
        tbl.push_back(C(0, CFG_MODE, {2'b00, WP_RW}, 0, 0));
        tbl.push_back(C(0, CFG_CNT, 4'h0, 0, 0));
        tbl.push_back(A(0, 1, 16'hC100, 8'h5A, 0, 1, K1));
        tbl.push_back(A(0, 0, 16'h0000, 8'h00, 1, 0, K1));
        tbl.push_back(C(1, CFG_ADDR, 4'h0, 0, K1));
        tbl.push_back(C(1, CFG_ADDR, 4'h4, 0, K1));
        tbl.push_back(C(1, CFG_ADDR, 4'hF, 0, K1));
        tbl.push_back(C(1, CFG_ADDR, 4'hF, 0, K1));
        tbl.push_back(C(1, CFG_MODE, {2'b00, WP_RD}, 0, K1));
        tbl.push_back(C(1, CFG_CNT, 4'h2, 0, K1));
        tbl.push_back(A(1, 0, 16'hFF40, 8'h11, 0, 0, K1));
        tbl.push_back(A(0, 1, 16'hFF40, 8'h22, 0, 0, K1));
        tbl.push_back(A(1, 0, 16'hFF40, 8'h23, 0, 0, K1));
        tbl.push_back(A(1, 0, 16'hFF40, 8'h33, 0, 1, K2));
        tbl.push_back(A(1, 0, 16'hFF40, 8'h44, 0, 1, K2));
        tbl.push_back(A(1, 0, 16'hFF40, 8'h55, 1, 0, K2));
        tbl.push_back(A(1, 0, 16'hFF40, 8'h56, 0, 0, K2));
        tbl.push_back(A(1, 0, 16'hFF40, 8'h57, 0, 0, K2));
        tbl.push_back(A(1, 0, 16'hFF40, 8'h66, 0, 1, K3));
        tbl.push_back(A(0, 0, 16'h0000, 8'h00, 1, 0, K3));
        for (int w = 0; w < 2; w++) begin
            tbl.push_back(C(2'(w), CFG_ADDR, 4'h0, 0, K3));
            tbl.push_back(C(2'(w), CFG_ADDR, 4'h0, 0, K3));
            tbl.push_back(C(2'(w), CFG_ADDR, 4'h0, 0, K3));
            tbl.push_back(C(2'(w), CFG_ADDR, 4'h8, 0, K3));
        end
        tbl.push_back(C(1, CFG_CNT, 4'h0, 0, K3));
        tbl.push_back(A(1, 0, 16'h8000, 8'h77, 0, 1, K4));
        tbl.push_back(A(0, 0, 16'h0000, 8'h00, 1, 0, K4));
        tbl.push_back(A(1, 0, 16'h8000, 8'h88, 0, 1, K5));
        tbl.push_back(C(0, CFG_MODE, {2'b00, WP_OFF}, 1, K5));
        tbl.push_back(A(0, 0, 16'h0000, 8'h00, 1, 0, K5));
        tbl.push_back(A(1, 0, 16'h8000, 8'h99, 0, 1, K6));
        tbl.push_back(R());
        tbl.push_back(A(0, 1, 16'h8000, 8'hAA, 0, 0, 0));
        tbl.push_back(A(1, 0, 16'hFF40, 8'hAB, 0, 0, 0));
        tbl.push_back(A(1, 0, 16'hC100, 8'hAC, 0, 0, 0));

        foreach (tbl[k]) begin
            drive(tbl[k]);
            check($sformatf("vec%0d", k), tbl[k].eh, tbl[k].ec);
        end

        drive(R());
        check("rnd_reset", m_halt, m_cap());
        for (int n = 0; n < 3000; n++) begin
            if (n % 256 == 0) begin
                for (int w = 0; w < N; w++) begin
                    p = pool[$urandom_range(0, 3)];
                    for (int k = 0; k < 4; k++) begin
                        drive(C(2'(w), CFG_ADDR, p[4*k +: 4], 0, 0));
                        check($sformatf("rnd_prog%0d_%0d", n, w), m_halt, m_cap());
                    end
                end
            end
            v = '{default: '0};
            v.rst = $urandom_range(0, 499) == 0;
            v.we  = $urandom_range(0, 5) == 0;
            v.wp  = 2'($urandom_range(0, 3));
            v.fld = $urandom_range(0, 15) == 0 ? CFG_ADDR : 2'($urandom_range(1, 3));
            v.nib = v.fld == CFG_CNT ? 4'($urandom_range(0, 3)) : 4'($urandom);
            r = $urandom_range(0, 3);
            v.rd  = r == 1;
            v.wr  = r == 2;
            v.adr = $urandom_range(0, 7) == 0 ? 16'($urandom) : pool[$urandom_range(0, 3)];
            v.db  = 8'($urandom);
            v.clr = $urandom_range(0, 4) == 0;
            drive(v);
            check($sformatf("rnd%0d", n), m_halt, m_cap());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
